// File: rtl/guess_target_gen.sv
// guess_target_gen: writer side of the dice game's lfsr_result target bus.
// A free-running x^7+x^6+1 LFSR is sampled when the player releases NEW_GAME.
// Out-of-range draws are redrawn up to MAX_TRIES times, then DEFAULT_TARGET
// is used instead. Define GUESS_TARGET_DEBOUNCE_EN to add a level debouncer
// of DEBOUNCE_CYCLES clocks after the input synchronizer.
module guess_target_gen #(
  parameter int unsigned MIN_TARGET      = 20,
  parameter int unsigned MAX_TARGET      = 99,
  parameter int unsigned DEFAULT_TARGET  = 50,
  parameter logic [6:0]  SEED            = 7'h5A,
  parameter int unsigned MAX_TRIES       = 8,
  parameter int          DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       NEW_GAME,
  output logic [6:0] lfsr_result,
  output logic       target_valid,
  output logic       busy,
  output logic [6:0] lfsr_state
);

  localparam int unsigned TW         = $clog2(MAX_TRIES + 1);
  localparam logic [6:0]  MIN7       = 7'(MIN_TARGET);
  localparam logic [6:0]  MAX7       = 7'(MAX_TARGET);
  localparam logic [6:0]  DEFAULT7   = 7'(DEFAULT_TARGET);
  localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [6:0]  SEED_EFF   = (SEED == 7'h00) ? 7'h01 : SEED;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    CHECK,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [6:0]    lfsr_q;
  logic          sync1;
  logic          sync2;
  logic          ng;
  logic          ng_d;
  logic          req;
  logic [6:0]    cand;
  logic [6:0]    cand_nx;
  logic [TW-1:0] tries;
  logic [TW-1:0] tries_nx;
  logic [6:0]    result_nx;
  logic          valid_nx;

  // Free-running LFSR; advances on every non-reset clock, independent of the FSM.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end
  end

  assign lfsr_state = lfsr_q;

  // Two-flop synchronizer for the raw button, plus the delayed conditioned level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      ng_d  <= 1'b0;
    end else begin
      sync1 <= NEW_GAME;
      sync2 <= sync1;
      ng_d  <= ng;
    end
  end

`ifdef GUESS_TARGET_DEBOUNCE_EN
  localparam int unsigned   DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [DBW-1:0] db_cnt;

  // Adopt a new level only after it has differed from ng for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ng     <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 == ng) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      ng     <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DBW'(1);
    end
  end
`else
  // No debouncer in this build: the conditioned level is the synchronizer output
  // and the debounce length is irrelevant.
  if (DEBOUNCE_CYCLES >= 0) begin : g_no_debounce
    assign ng = sync2;
  end else begin : g_no_debounce_any
    assign ng = sync2;
  end
`endif

  // A request is a button release, the same edge the game core acts on.
  assign req = ng_d & ~ng;

  // FSM state and datapath registers; reset restores the settled default target.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      cand         <= '0;
      tries        <= '0;
      lfsr_result  <= DEFAULT7;
      target_valid <= 1'b1;
    end else begin
      state        <= state_nx;
      cand         <= cand_nx;
      tries        <= tries_nx;
      lfsr_result  <= result_nx;
      target_valid <= valid_nx;
    end
  end

  // Next-state and datapath decode; requests seen outside IDLE are dropped.
  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    tries_nx  = tries;
    result_nx = lfsr_result;
    valid_nx  = target_valid;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = DRAW;
          valid_nx = 1'b0;
          tries_nx = '0;
        end
      end
      DRAW: begin
        cand_nx  = lfsr_q;
        tries_nx = tries + TW'(1);
        state_nx = CHECK;
      end
      CHECK: begin
        if ((cand >= MIN7) && (cand <= MAX7)) begin
          result_nx = cand;
          state_nx  = DONE;
        end else if (tries == TRIES_LAST) begin
          result_nx = DEFAULT7;
          state_nx  = DONE;
        end else begin
          state_nx = DRAW;
        end
      end
      DONE: begin
        valid_nx = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/guess_target_gen.md
# guess_target_gen

Target-score generator for the dice guessing game: the writer side of the `lfsr_result` target bus that the game core reads. A free-running 7-bit LFSR is sampled when the player releases NEW_GAME. Out-of-range samples are rejected and redrawn, and the accepted value is held on `lfsr_result` with a valid flag. Sits between the board button and the game core, on the same CLK.

## Interface
- MIN_TARGET, 20: smallest acceptable target, 1..MAX_TARGET
- MAX_TARGET, 99: largest acceptable target, ≤127
- DEFAULT_TARGET, 50: target after reset and after retry exhaustion
- SEED, 7'h5A: LFSR reset value; 0 is replaced by 7'h01
- MAX_TRIES, 8: draws per request before fallback, ≥1
- DEBOUNCE_CYCLES, 500000: stable-level cycles required, debounce build only
- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-high
- NEW_GAME  in  1  raw asynchronous push-button, active-high
- lfsr_result  out  7  current target, registered
- target_valid  out  1  high when lfsr_result is a settled target
- busy  out  1  high while FSM not in IDLE
- lfsr_state  out  7  live LFSR register, for bench prediction

## Operation
- LFSR: Fibonacci, x^7+x^6+1; next = {q[5:0], q[6]^q[5]}; advances every non-reset cycle regardless of FSM state; period 127, never 0. Press timing supplies the randomness.
- Input path: 2-flop synchronizer on NEW_GAME. The result passes through the optional debounce (see Configuration) to give conditioned level `ng`, which has a registered copy `ng_d`.
- Request event: `ng_d==1 && ng==0` (button release), matching the game core, which also acts on release.
- FSM states IDLE, DRAW, CHECK, DONE:
  - IDLE: on event, go to DRAW; target_valid<=0; tries<=0.
  - DRAW: cand<=lfsr_state; tries<=tries+1; go to CHECK.
  - CHECK:
    - If MIN_TARGET≤cand≤MAX_TARGET: lfsr_result<=cand; go to DONE.
    - Else if tries==MAX_TRIES: lfsr_result<=DEFAULT_TARGET; go to DONE.
    - Else: go to DRAW.
  - DONE: target_valid<=1; go to IDLE.
- Events outside IDLE are dropped, not queued.
- lfsr_result holds its previous value throughout a draw; it changes only in CHECK.
- Comparisons are 7-bit unsigned. tries counter width is clog2(MAX_TRIES+1).

## Timing
- Reset values:
  - lfsr_result=DEFAULT_TARGET, target_valid=1, busy=0, lfsr_state=SEED (or 7'h01 if SEED is 0)
  - FSM in IDLE; synchronizer flops, ng and ng_d all 0; debounce counter 0
- Raw edge to conditioned level: 2 clocks without debounce; 2+DEBOUNCE_CYCLES with debounce.
- Event cycle E (the edge where the FSM leaves IDLE):
  - target_valid low after edge E
  - cand sampled at edge E+1, equal to lfsr_state as seen during cycle E+1
  - First-draw accept: lfsr_result updates at E+2; target_valid high after E+3
  - Each rejection adds 2 clocks
  - Fallback: target_valid high after E+2·MAX_TRIES+1
- busy high from after E until the DONE edge.
- RESET mid-draw: FSM returns to IDLE, all outputs take reset values, the draw is abandoned.
- NEW_GAME held through reset: no event until a release is seen after reset.

## Configuration
- Macro: GUESS_TARGET_DEBOUNCE_EN.
- Defined: ng copies the synchronized input only after it differs from ng for DEBOUNCE_CYCLES consecutive clocks. Any return to equality clears the counter. Counter width is clog2(DEBOUNCE_CYCLES+1).
- Undefined: ng equals the synchronizer output. DEBOUNCE_CYCLES is unused, and no counter is present.

## Test plan
- Reset with defaults: lfsr_result=50, target_valid=1, busy=0, lfsr_state=7'h5A. After the next clocks lfsr_state reads 7'h35, 7'h6B, 7'h56, 7'h2D.
- Defaults, debounce off: press 5 clocks then release. target_valid falls after E. lfsr_result equals lfsr_state sampled at E+1 if that value is in 20..99, and target_valid rises at E+3. Otherwise the bench model predicts the redraw.
- MIN_TARGET=MAX_TARGET=127, MAX_TRIES=1, release timed so the sample ≠7'h7F: lfsr_result=50, target_valid rises after E+3.
- Second press and release while busy: ignored. Exactly one valid rise; lfsr_result matches a single-request model.
- RESET asserted at E+1: next clock gives lfsr_result=50, target_valid=1, busy=0, lfsr_state=SEED.
- With GUESS_TARGET_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: a 3-clock glitch gives no event. A press held 10 clocks then released gives one event 6 clocks after the raw release edge.
